// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a shared multicycle MIPS datapath (R-type, lw, sw, beq, j; addi with ADDI_EN)
// Optional feature: define ADDI_EN to decode Op=001000 (addi) through EXEC_I/IWB; otherwise addi is illegal.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   Op                instruction[31:26] from IR, stable from DECODE to instruction end
//   mem_ready         memory completes the current read/write this cycle
//   PCWrite..RegDst   datapath controls; all zero unless the current state asserts them
//   InstrDone         pulse on the final cycle of each retired instruction
//   IllegalOp         pulse in DECODE on an unsupported opcode
//   InstrCount        retired-instruction counter, wraps modulo 2^CNT_W
//   State             current state encoding for debug
module multicycle_control #(
  parameter int unsigned CNT_W = 16,
  parameter logic [5:0] JUMP_OP = 6'b000010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             InstrDone,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);
`ifdef ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_EXEC_I, S_IWB
  } state_t;
  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw;
    logic       rdst;
    logic       done;
  } ctl_t;
  state_t state_q, state_d, dec_nxt;
  ctl_t ctl_q;
  logic [CNT_W-1:0] cnt_q;
  // Per-state Moore controls; registered against the next state so they line up with state_q.
  function automatic ctl_t moore(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mrd = 1'b1; c.srcb = 2'b01; end
      S_DECODE: c.srcb = 2'b11;
      S_MEMADR: begin c.srca = 1'b1; c.srcb = 2'b10; end
      S_MEMRD:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.srca = 1'b1; c.aluop = 2'b10; end
      S_RWB:    begin c.rw = 1'b1; c.rdst = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1; end
      S_JUMP:   begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; end
      S_EXEC_I: if (ADDI_ON) begin c.srca = 1'b1; c.srcb = 2'b10; end
      S_IWB:    if (ADDI_ON) begin c.rw = 1'b1; c.done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    dec_nxt = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
              (Op == OP_R) ? S_EXEC :
              (Op == OP_BEQ) ? S_BRANCH :
              (Op == JUMP_OP) ? S_JUMP :
              (ADDI_ON && Op == OP_ADDI) ? S_EXEC_I : S_FETCH;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_nxt;
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_EXEC_I: state_d = ADDI_ON ? S_IWB : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    if (rst) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ctl_q   <= moore(state_d);
    cnt_q   <= rst ? '0 : cnt_q + CNT_W'(InstrDone);
  end
  // IRWrite/PCWrite in FETCH and completion in MEMWR follow mem_ready in the same cycle.
  assign IRWrite     = state_q == S_FETCH && mem_ready;
  assign PCWrite     = ctl_q.pcw | IRWrite;
  assign InstrDone   = ctl_q.done | (state_q == S_MEMWR && mem_ready);
  assign IllegalOp   = state_q == S_DECODE && dec_nxt == S_FETCH;
  assign PCWriteCond = ctl_q.pcwc;
  assign IorD        = ctl_q.iord;
  assign MemRead     = ctl_q.mrd;
  assign MemWrite    = ctl_q.mwr;
  assign MemtoReg    = ctl_q.m2r;
  assign PCSource    = ctl_q.pcsrc;
  assign ALUOp       = ctl_q.aluop;
  assign ALUSrcA     = ctl_q.srca;
  assign ALUSrcB     = ctl_q.srcb;
  assign RegWrite    = ctl_q.rw;
  assign RegDst      = ctl_q.rdst;
  assign InstrCount  = cnt_q;
  assign State       = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench for multicycle_control with a 2-bit retire counter
module tb_multicycle_control;
  logic clk = 1'b0, rst, mem_ready;
  logic [5:0] Op;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst, InstrDone, IllegalOp;
  logic [1:0] InstrCount;
  logic [3:0] State;
  int total = 0, bad = 0;
  logic [1:0] exp_cnt = 2'd0;
  typedef struct {int len; logic [1:0] cnt; int mask; bit ill;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  multicycle_control #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
    .InstrCount(InstrCount), .State(State)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expected Moore controls {PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst}
  function automatic logic [13:0] exp_ctl(input logic [3:0] s);
    case (s)
      4'd1:  return {1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0};
      4'd2:  return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0};
      4'd3:  return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0};
      4'd4:  return {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
      4'd5:  return {1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
      4'd6:  return {1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
      4'd7:  return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0};
      4'd8:  return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1};
      4'd9:  return {1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0};
      4'd10: return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0};
`ifdef ADDI_EN
      4'd11: return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0};
      4'd12: return {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
`endif
      default: return '0;
    endcase
  endfunction
  function automatic logic [13:0] obs_ctl();
    return {PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
  endfunction
  // Runs one instruction from FETCH back to FETCH, checking every cycle, then scores it.
  task automatic do_instr(input string nm, input logic [5:0] op, input int fw, input int mw,
                          input int len, input int mask, input bit ill);
    int n = 0, fc = 0, mc = 0, vis = 0, irs = 0, dns = 0, ils = 0;
    bit left = 0;
    logic [3:0] st;
    exp_t e;
    if (!ill) exp_cnt = exp_cnt + 2'd1;
    sb.push_back('{len, exp_cnt, mask, ill});
    Op = op;
    chk({nm, " start_state"}, State, 4'd1);
    while (n < 40 && !(left && State == 4'd1)) begin
      st = State;
      vis |= 1 << st;
      mem_ready = (st == 4'd1) ? (fc >= fw) : (st == 4'd4 || st == 4'd6) ? (mc >= mw) : 1'($urandom_range(0, 1));
      if (st == 4'd1) fc++;
      if (st == 4'd4 || st == 4'd6) mc++;
      #1;
      chk({nm, " ctl"}, obs_ctl(), exp_ctl(st));
      chk({nm, " PCWrite"}, PCWrite, st == 4'd10 || (st == 4'd1 && mem_ready));
      chk({nm, " InstrDone"}, InstrDone, st == 4'd5 || st == 4'd8 || st == 4'd9 || st == 4'd10 || st == 4'd12 || (st == 4'd6 && mem_ready));
      chk({nm, " IllegalOp"}, IllegalOp, st == 4'd2 && ill);
      chk({nm, " rd_wr_excl"}, MemRead & MemWrite, 1'b0);
      irs += int'(IRWrite);
      dns += int'(InstrDone);
      ils += int'(IllegalOp);
      @(posedge clk);
      #1;
      n++;
      if (State != 4'd1) left = 1;
    end
    e = sb.pop_front();
    chk({nm, " cycles"}, n, e.len);
    chk({nm, " visited"}, vis, e.mask);
    chk({nm, " count"}, InstrCount, e.cnt);
    chk({nm, " irwrite_pulses"}, irs, 1);
    chk({nm, " done_pulses"}, dns, e.ill ? 0 : 1);
    chk({nm, " illegal_pulses"}, ils, e.ill ? 1 : 0);
  endtask
  initial begin
    int n;
    rst = 1'b1; mem_ready = 1'b1; Op = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", State, 4'd0);
    chk("reset_ctl", obs_ctl(), 14'd0);
    chk("reset_misc", {PCWrite, IRWrite, InstrDone, IllegalOp}, 4'd0);
    chk("reset_count", InstrCount, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_to_fetch", State, 4'd1);
    do_instr("rtype", 6'b000000, 0, 0, 4, 32'h186, 0);
    do_instr("lw_wait", 6'b100011, 2, 3, 10, 32'h3e, 0);
    do_instr("sw", 6'b101011, 0, 0, 4, 32'h4e, 0);
    do_instr("beq", 6'b000100, 0, 0, 3, 32'h206, 0);
    do_instr("j", 6'b000010, 0, 0, 3, 32'h406, 0);
    do_instr("sw_wait", 6'b101011, 1, 2, 7, 32'h4e, 0);
    do_instr("illegal", 6'b111111, 0, 0, 2, 32'h6, 1);
`ifdef ADDI_EN
    do_instr("addi", 6'b001000, 0, 0, 4, 32'h1806, 0);
`else
    do_instr("addi_illegal", 6'b001000, 0, 0, 2, 32'h6, 1);
`endif
    do_instr("lw", 6'b100011, 0, 0, 5, 32'h3e, 0);
    Op = 6'b100011; mem_ready = 1'b1; n = 0;
    while (State != 4'd4 && n < 10) begin @(posedge clk); #1; n++; end
    chk("reach_memrd", State, 4'd4);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("memrd_hold", State, 4'd4);
    chk("memrd_read", MemRead, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", State, 4'd0);
    chk("abort_memread", MemRead, 1'b0);
    chk("abort_count", InstrCount, 2'd0);
    rst = 1'b0; mem_ready = 1'b1; exp_cnt = 2'd0;
    @(posedge clk); #1;
    do_instr("rtype_after_abort", 6'b000000, 0, 0, 4, 32'h186, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: a single memory, a single ALU, the IR, and PC/A/B/ALUOut registers.
- Issues per-state datapath controls for R-type, lw, sw, beq and j.
- Stretches memory states on a ready handshake and counts retired instructions.
- Replaces per-instruction single-cycle decode where the datapath is time-shared across cycles.

Parameters:
- CNT_W, 16, width of retired-instruction counter InstrCount.
- JUMP_OP, 6'b000010, opcode decoded as j.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Op  input  6  instruction[31:26] from IR; stable from DECODE until instruction end
- mem_ready  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  PC write qualified by ALU Zero (beq)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load IR
- MemtoReg  output  1  write-back select: 1=MDR, 0=ALUOut
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- RegWrite  output  1  register file write enable
- RegDst  output  1  1=rd, 0=rt
- InstrDone  output  1  one-cycle pulse on final cycle of each retired instruction
- IllegalOp  output  1  one-cycle pulse in DECODE on unsupported opcode
- InstrCount  output  CNT_W  retired-instruction count; wraps to 0 past max
- State  output  4  current state encoding, for debug

Behaviour:
- Outputs default to 0 in every state; only the listed signals are asserted.
- Reset: rst sampled high forces State=IDLE and InstrCount=0 on that edge; any in-flight instruction is aborted; no pending memory request persists.
- IDLE(0): all outputs 0. Next state FETCH.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (only Mealy term).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - JUMP_OP -> JUMP
  - ADDI_EN build only: 001000 -> EXEC_I
  - otherwise -> FETCH with IllegalOp=1; InstrDone stays 0; counter unchanged.
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Op=100011 -> MEMRD, else MEMWR.
- MEMRD(4): MemRead=1, IorD=1. Held until mem_ready=1, then -> MEMWB.
- MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. -> FETCH.
- MEMWR(6): MemWrite=1, IorD=1. Held until mem_ready=1; that cycle InstrDone=1, then -> FETCH.
- EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RWB.
- RWB(8): RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. -> FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1. -> FETCH.
- JUMP(10): PCWrite=1, PCSource=10, InstrDone=1. -> FETCH.
- Unused encodings 11–15 (11–15 when ADDI_EN is off; 13–15 when on): all outputs 0, next state FETCH.
- InstrCount increments by 1 on every edge where InstrDone=1 and rst=0; modulo 2^CNT_W.
- Latency with mem_ready tied high, in cycles: lw 5, sw 4, R-type 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- MemRead and MemWrite are never both 1.

Optional Feature:
- Macro: ADDI_EN.
- Defined:
  - Op=001000 in DECODE -> EXEC_I(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - EXEC_I -> IWB(12): RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1, then -> FETCH.
  - addi latency 4.
- Undefined: 001000 is illegal; IllegalOp pulses and the FSM returns to FETCH.

Test Plan:
- rst=1 for 2 cycles then 0, mem_ready=1 -> State 0 then 1; all outputs 0 in IDLE; InstrCount=0.
- R-type (Op=000000), mem_ready=1 -> states 1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB; InstrDone once; InstrCount=1.
- lw (100011), mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; IRWrite pulses exactly once; MemRead continuously high through MEMRD; InstrCount +1.
- sw then beq then j, mem_ready=1 -> durations 4/3/3; PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP; InstrCount +3.
- Op=111111 (and 001000 without ADDI_EN) -> IllegalOp single pulse in DECODE; next state FETCH; InstrCount unchanged.
- rst asserted in MEMRD while mem_ready=0 -> next state IDLE; MemRead=0; InstrCount=0.
- InstrCount wrap: CNT_W=2, retire 5 instructions -> reads 1.
